// File: rtl/ipdb_sar_pwrup_seq_pkg.sv
// -----------------------------------------------------------------------------
// ipdb_sar_pkg
// Shared types and defaults for the SAR ADC power-up sequencer.
//   sar_seq_state_t        : sequencer state, 3-bit encoding visible on state_o
//   SAR_SEQ_CNT_W_DEFAULT  : default width of the shared settle/timeout counter
// -----------------------------------------------------------------------------
package ipdb_sar_pkg;

   typedef enum logic [2:0] {
      SEQ_OFF   = 3'd0,
      SEQ_BIAS  = 3'd1,
      SEQ_REF   = 3'd2,
      SEQ_CAL   = 3'd3,
      SEQ_READY = 3'd4,
      SEQ_ERR   = 3'd5
   } sar_seq_state_t;

   localparam int SAR_SEQ_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/ipdb_sar_pwrup_seq_if.sv
// -----------------------------------------------------------------------------
// ipdb_sar_pwrup_seq_if
// Control/status bundle between the SAR power-up sequencer and its environment.
// Signal names carry the sequencer's point of view (_i into it, _o out of it).
//   enable_i    : sequencer enable, level
//   cal_done_i  : calibration finished, level
//   bias_en_o   : analog bias enable
//   ref_en_o    : reference buffer enable
//   cal_start_o : one-cycle calibration start pulse
//   ready_o     : core ready for conversions
//   err_o       : calibration timeout flag (sticky until disable)
//   state_o     : current sequencer state code
// Modports: master = environment/controller, slave = sequencer.
//
// Handshake: there is no valid/ready pair. enable_i is a level request; the
// sequencer answers by walking bias -> ref -> cal and holding ready_o. The
// calibration engine answers the cal_start_o pulse by raising cal_done_i, which
// is taken as a level in any CAL cycle.
// -----------------------------------------------------------------------------
interface ipdb_sar_pwrup_seq_if;

   logic       enable_i;
   logic       cal_done_i;
   logic       bias_en_o;
   logic       ref_en_o;
   logic       cal_start_o;
   logic       ready_o;
   logic       err_o;
   logic [2:0] state_o;

   modport master (
      output enable_i,
      output cal_done_i,
      input  bias_en_o,
      input  ref_en_o,
      input  cal_start_o,
      input  ready_o,
      input  err_o,
      input  state_o
   );

   modport slave (
      input  enable_i,
      input  cal_done_i,
      output bias_en_o,
      output ref_en_o,
      output cal_start_o,
      output ready_o,
      output err_o,
      output state_o
   );

endinterface

// File: rtl/ipdb_common_dcnt.sv
// -----------------------------------------------------------------------------
// ipdb_common_dcnt
// Loadable down-counter. Load has priority over decrement; decrement saturates
// at zero so a stray dec never wraps into a long count.
//   clk_i, reset_n_i : clock, asynchronous active-low reset (count -> 0)
//   load_i, load_val_i : synchronous load
//   dec_i            : decrement by one this cycle
//   zero_o           : count is zero
// -----------------------------------------------------------------------------
module ipdb_common_dcnt #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ipdb_sar_pwrup_seq.sv
// -----------------------------------------------------------------------------
// ipdb_sar_pwrup_seq
// Power-up sequencer for the SAR ADC analog core: bias enable, settle,
// reference enable, settle, calibration start and wait, then ready. A dropped
// enable returns to OFF from anywhere; a calibration timeout parks in ERR until
// enable drops.
//   clk_i     : ADC digital clock
//   reset_n_i : asynchronous active-low reset (from the reset synchronizer)
//   seq_if    : slave side of ipdb_sar_pwrup_seq_if (enable/cal_done in,
//               enables, cal_start pulse, ready, err and state code out)
// All outputs are registered and computed from the next state, so each output
// changes on the same edge as the state it belongs to.
// -----------------------------------------------------------------------------
module ipdb_sar_pwrup_seq
   import ipdb_sar_pkg::*;
#(
   parameter int BIAS_SETTLE_CYC = 64,
   parameter int REF_SETTLE_CYC  = 32,
   parameter int CAL_TIMEOUT_CYC = 200,
   parameter int CNT_W           = SAR_SEQ_CNT_W_DEFAULT
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   ipdb_sar_pwrup_seq_if.slave  seq_if
);

   // The counter is loaded with N-1 on entry and the exit is taken on the
   // cycle it reads zero, giving exactly N edges in the state.
   localparam logic [CNT_W-1:0] BIAS_LD = CNT_W'(BIAS_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] REF_LD  = CNT_W'(REF_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] CAL_LD  = CNT_W'(CAL_TIMEOUT_CYC - 1);

   sar_seq_state_t   state_q, state_d;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             cnt_zero;

   logic bias_en_q,   bias_en_d;
   logic ref_en_q,    ref_en_d;
   logic cal_start_q, cal_start_d;
   logic ready_q,     ready_d;
   logic err_q,       err_d;

   ipdb_common_dcnt #(
      .W (CNT_W)
   ) u_dcnt (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      cnt_dec      = 1'b0;
      cnt_load_val = '0;

      case (state_q)
         SEQ_OFF: begin
            if (seq_if.enable_i) state_d = SEQ_BIAS;
         end
         SEQ_BIAS: begin
            if (cnt_zero) state_d = SEQ_REF;
            else          cnt_dec = 1'b1;
         end
         SEQ_REF: begin
            if (cnt_zero) state_d = SEQ_CAL;
            else          cnt_dec = 1'b1;
         end
         SEQ_CAL: begin
            // done wins over a timeout in the same cycle
            if (seq_if.cal_done_i) state_d = SEQ_READY;
            else if (cnt_zero)     state_d = SEQ_ERR;
            else                   cnt_dec = 1'b1;
         end
         SEQ_READY, SEQ_ERR: begin
            state_d = state_q;
         end
         default: begin
            // unused codes 6/7
            state_d = SEQ_OFF;
         end
      endcase

      // disable overrides every other transition
      if (!seq_if.enable_i) begin
         state_d = SEQ_OFF;
         cnt_dec = 1'b0;
      end

      // every state entry reloads the counter
      cnt_load = (state_d != state_q);
      case (state_d)
         SEQ_BIAS: cnt_load_val = BIAS_LD;
         SEQ_REF:  cnt_load_val = REF_LD;
         SEQ_CAL:  cnt_load_val = CAL_LD;
         default:  cnt_load_val = '0;
      endcase

      bias_en_d   = state_d inside {SEQ_BIAS, SEQ_REF, SEQ_CAL, SEQ_READY};
      ref_en_d    = state_d inside {SEQ_REF, SEQ_CAL, SEQ_READY};
      ready_d     = (state_d == SEQ_READY);
      err_d       = (state_d == SEQ_ERR);
      cal_start_d = (state_q == SEQ_REF) && (state_d == SEQ_CAL);
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= SEQ_OFF;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         bias_en_q   <= 1'b0;
         ref_en_q    <= 1'b0;
         cal_start_q <= 1'b0;
         ready_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         bias_en_q   <= bias_en_d;
         ref_en_q    <= ref_en_d;
         cal_start_q <= cal_start_d;
         ready_q     <= ready_d;
         err_q       <= err_d;
      end
   end

   assign seq_if.bias_en_o   = bias_en_q;
   assign seq_if.ref_en_o    = ref_en_q;
   assign seq_if.cal_start_o = cal_start_q;
   assign seq_if.ready_o     = ready_q;
   assign seq_if.err_o       = err_q;
   assign seq_if.state_o     = state_q;

endmodule

// File: tb/tb_ipdb_sar_pwrup_seq.sv
// -----------------------------------------------------------------------------
// tb_ipdb_sar_pwrup_seq
// Two sequencers share one stimulus stream: instance A with short settle
// times (4/3/5) and instance B at the minimum (1/1/1). A reference model counts
// edges spent in each phase and pushes the expected output vector for every
// clock into a per-instance queue; a monitor pops and compares on the falling
// edge. Async reset is asserted between edges, so the next falling-edge sample
// shows whether outputs cleared without waiting for a clock.
// Vector layout: {state[2:0], bias_en, ref_en, cal_start, ready, err}
// -----------------------------------------------------------------------------
module tb_ipdb_sar_pwrup_seq;

   localparam int A_BIAS = 4;
   localparam int A_REF  = 3;
   localparam int A_CAL  = 5;
   localparam int B_BIAS = 1;
   localparam int B_REF  = 1;
   localparam int B_CAL  = 1;

   localparam int M_OFF   = 0;
   localparam int M_BIAS  = 1;
   localparam int M_REF   = 2;
   localparam int M_CAL   = 3;
   localparam int M_READY = 4;
   localparam int M_ERR   = 5;

   logic clk;
   logic rst_n;

   ipdb_sar_pwrup_seq_if if_a ();
   ipdb_sar_pwrup_seq_if if_b ();

   ipdb_sar_pwrup_seq #(
      .BIAS_SETTLE_CYC (A_BIAS),
      .REF_SETTLE_CYC  (A_REF),
      .CAL_TIMEOUT_CYC (A_CAL),
      .CNT_W           (8)
   ) dut_a (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .seq_if    (if_a)
   );

   ipdb_sar_pwrup_seq #(
      .BIAS_SETTLE_CYC (B_BIAS),
      .REF_SETTLE_CYC  (B_REF),
      .CAL_TIMEOUT_CYC (B_CAL),
      .CNT_W           (8)
   ) dut_b (
      .clk_i     (clk),
      .reset_n_i (rst_n),
      .seq_if    (if_b)
   );

   logic [7:0] exp_a_q[$];
   logic [7:0] exp_b_q[$];

   int   n_checks;
   int   n_pass;
   int   cyc;
   int   st_a, k_a, st_b, k_b;
   logic cur_en, cur_done;

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] exp_vec(input int st, input bit cs);
      logic [2:0] s3;
      s3 = 3'(st);
      return {s3, (st >= M_BIAS && st <= M_READY), (st >= M_REF && st <= M_READY),
              cs, (st == M_READY), (st == M_ERR)};
   endfunction

   // k = edges already spent in the current state. A state with a settle time
   // of N is left on the N-th edge after entry.
   task automatic model_step(input int st, input int k, input logic en, input logic done,
                             input int bias_c, input int ref_c, input int cal_c,
                             output int nst, output int nk, output bit cs);
      nst = st;
      cs  = 1'b0;
      if (!en) begin
         nst = M_OFF;
      end else begin
         case (st)
            M_OFF:  nst = M_BIAS;
            M_BIAS: if (k + 1 == bias_c) nst = M_REF;
            M_REF:  if (k + 1 == ref_c) begin nst = M_CAL; cs = 1'b1; end
            M_CAL: begin
               if (done)                nst = M_READY;
               else if (k + 1 == cal_c) nst = M_ERR;
            end
            default: nst = st;
         endcase
      end
      nk = (nst != st) ? 0 : k + 1;
   endtask

   // ---------------- driver ----------------
   // Models the edge just taken with the inputs applied before it, optionally
   // asserts reset (between edges), pushes the expectation for this cycle,
   // then applies the inputs for the next edge.
   task automatic step(input logic en, input logic done, input logic rst_assert);
      int nst, nk;
      bit cs_a, cs_b;
      @(posedge clk);
      #1;
      cyc++;
      cs_a = 1'b0;
      cs_b = 1'b0;
      if (!rst_n) begin
         st_a = M_OFF; k_a = 0;
         st_b = M_OFF; k_b = 0;
      end else begin
         model_step(st_a, k_a, cur_en, cur_done, A_BIAS, A_REF, A_CAL, nst, nk, cs_a);
         st_a = nst; k_a = nk;
         model_step(st_b, k_b, cur_en, cur_done, B_BIAS, B_REF, B_CAL, nst, nk, cs_b);
         st_b = nst; k_b = nk;
      end
      if (rst_assert) begin
         rst_n = 1'b0;
         st_a = M_OFF; k_a = 0; cs_a = 1'b0;
         st_b = M_OFF; k_b = 0; cs_b = 1'b0;
      end else begin
         rst_n = 1'b1;
      end
      exp_a_q.push_back(exp_vec(st_a, cs_a));
      exp_b_q.push_back(exp_vec(st_b, cs_b));
      cur_en            = en;
      cur_done          = done;
      if_a.enable_i     = en;
      if_a.cal_done_i   = done;
      if_b.enable_i     = en;
      if_b.cal_done_i   = done;
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_vec(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s cycle %0d: got state=%0d bias/ref/cs/rdy/err=%b, required state=%0d bias/ref/cs/rdy/err=%b",
                  name, cyc, act[7:5], act[4:0], exp[7:5], exp[4:0]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_a_q.size() != 0)
            check_vec("seq_a", {if_a.state_o, if_a.bias_en_o, if_a.ref_en_o, if_a.cal_start_o,
                                if_a.ready_o, if_a.err_o}, exp_a_q.pop_front());
         if (exp_b_q.size() != 0)
            check_vec("seq_b", {if_b.state_o, if_b.bias_en_o, if_b.ref_en_o, if_b.cal_start_o,
                                if_b.ready_o, if_b.err_o}, exp_b_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   logic en_r;
   logic done_r;
   logic rst_r;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      cyc      = 0;
      st_a = M_OFF; k_a = 0;
      st_b = M_OFF; k_b = 0;
      rst_n    = 1'b0;
      cur_en   = 1'b0;
      cur_done = 1'b0;
      if_a.enable_i = 1'b0; if_a.cal_done_i = 1'b0;
      if_b.enable_i = 1'b0; if_b.cal_done_i = 1'b0;

      // reset state, then release
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);

      // nominal sequence with late done
      repeat (10) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (4) step(1'b1, 1'b0, 1'b0);

      // disable, then calibration timeout with sticky err
      repeat (2) step(1'b0, 1'b0, 1'b0);
      repeat (22) step(1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);

      // done already high in the cal_start cycle
      repeat (14) step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);

      // abort two cycles into BIAS, then full restart
      repeat (3) step(1'b1, 1'b0, 1'b0);
      repeat (2) step(1'b0, 1'b0, 1'b0);
      repeat (12) step(1'b1, 1'b1, 1'b0);

      // async reset while READY
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0, 1'b0);

      // randomized run
      en_r = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (en_r) en_r = ($urandom_range(0, 39) != 0);
         else      en_r = ($urandom_range(0, 2) == 0);
         done_r = ($urandom_range(0, 3) == 0);
         rst_r  = ($urandom_range(0, 199) == 0);
         step(en_r, done_r, rst_r);
      end

      repeat (3) step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1;

      n_checks++;
      if (exp_a_q.size() == 0) n_pass++;
      else $display("FAIL drain_a: got %0d entries left, required 0", exp_a_q.size());
      n_checks++;
      if (exp_b_q.size() == 0) n_pass++;
      else $display("FAIL drain_b: got %0d entries left, required 0", exp_b_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ipdb_sar_pwrup_seq.md
Name: ipdb_sar_pwrup_seq

Overview:
- Power-up sequencer for the SAR ADC analog core.
- Sits directly downstream of the reset synchronizer: its reset_n_i is driven by the synchronizer's synchronous reset output in the clk_i domain.
- Steps the core through bias enable, reference enable and offset calibration with programmable settle times, then flags the core ready.
- Falls back to OFF on disable and to ERR on a calibration timeout.

Parameters:
- BIAS_SETTLE_CYC, 64, cycles bias_en_o is high before ref_en_o rises; range 1..2**CNT_W.
- REF_SETTLE_CYC, 32, cycles ref_en_o is high before cal_start_o pulses; range 1..2**CNT_W.
- CAL_TIMEOUT_CYC, 200, maximum cycles spent in CAL waiting for cal_done_i; range 1..2**CNT_W.
- CNT_W, 8, width of the shared down-counter.

Ports:
- clk_i  in  1  ADC digital clock.
- reset_n_i  in  1  asynchronous active-low reset, driven from the synchronized reset.
- enable_i  in  1  sequencer enable, synchronous to clk_i; level-sensitive.
- cal_done_i  in  1  calibration finished, synchronous, level.
- bias_en_o  out  1  analog bias enable.
- ref_en_o  out  1  reference buffer enable.
- cal_start_o  out  1  single-cycle calibration start pulse.
- ready_o  out  1  core ready for conversions.
- err_o  out  1  calibration timeout flag.
- state_o  out  3  current state encoding, for debug/status.

Behaviour:
- Clock, reset and registers:
  - One clock domain; reset is asynchronous and active-low, on clk_i / reset_n_i.
  - All outputs are registered.
  - Reset values: all outputs 0, state_o = OFF, counter = 0.
- States and encodings: OFF=0, BIAS=1, REF=2, CAL=3, READY=4, ERR=5. Codes 6 and 7 recover to OFF on the next edge.
- Shared down-counter: cnt, CNT_W bits. It is loaded on every state entry and decrements once per cycle in BIAS, REF and CAL.
- OFF:
  - Outputs bias_en=0, ref_en=0, ready=0, err=0.
  - enable_i=1 → BIAS; load cnt = BIAS_SETTLE_CYC-1.
- BIAS:
  - Outputs bias_en=1.
  - cnt==0 → REF; load cnt = REF_SETTLE_CYC-1.
  - Result: ref_en_o rises exactly BIAS_SETTLE_CYC edges after bias_en_o.
- REF:
  - Outputs bias_en=1, ref_en=1.
  - cnt==0 → CAL; load cnt = CAL_TIMEOUT_CYC-1; cal_start_o=1 for exactly that one cycle.
  - Result: the cal_start_o pulse is exactly REF_SETTLE_CYC edges after ref_en_o rises.
- CAL:
  - Outputs bias_en=1, ref_en=1.
  - cal_done_i=1 is accepted in any CAL cycle, including the cal_start_o cycle, and gives → READY (ready_o=1 from the next edge).
  - cnt==0 with cal_done_i=0 → ERR.
  - cal_done_i=1 in the same cycle as cnt==0 → READY; done wins.
- READY:
  - Outputs bias_en=1, ref_en=1, ready=1.
  - Remains here while enable_i=1; cal_done_i is ignored.
- ERR:
  - Outputs bias_en=0, ref_en=0, ready=0, err=1.
  - err_o is sticky until enable_i=0.
  - Exit only via enable_i=0 → OFF; no automatic retry.
- Disable (enable_i=0):
  - Sampled in any state, goes → OFF on the next edge.
  - All enables, ready_o and err_o drop on that same edge.
  - A cal_start_o pulse in flight is not re-issued.
  - Disable has priority over every other transition.
- Re-enable: only from OFF, and always restarts from BIAS. There is no partial resume.
- Reset: asserting reset_n_i in any state clears all outputs immediately (asynchronous) and goes to OFF. After deassertion, enable_i is sampled from the first edge.
- cal_start_o is never high outside the REF→CAL transition cycle.

Decomposition:
- Package ipdb_sar_pkg holds:
  - the state typedef sar_seq_state_t (3-bit enum, encodings above);
  - the localparam SAR_SEQ_CNT_W_DEFAULT = 8.
- Optional sub-module ipdb_common_dcnt: a loadable down-counter with load, dec and zero outputs, parameterised by width.
- The FSM and output registers remain in ipdb_sar_pwrup_seq.

Test Plan:
- Nominal sequence (BIAS_SETTLE_CYC=4, REF_SETTLE_CYC=3): reset release, enable_i=1 at edge 0 → bias_en_o at edge 1, ref_en_o at edge 5, cal_start_o high for edge 8 only. cal_done_i=1 at edge 10 → ready_o at edge 11.
- Calibration timeout (CAL_TIMEOUT_CYC=5): cal_done_i held 0 → ERR 5 cycles after entering CAL, with err_o=1 and bias_en_o=ref_en_o=0. enable_i=0 → err_o=0 and state OFF on the next edge.
- Early done: cal_done_i=1 already high during the cal_start_o cycle → READY on the next edge, with no ERR.
- Abort mid-BIAS: enable_i drops 2 cycles into BIAS → all outputs 0 on the next edge. Re-enable → full BIAS_SETTLE_CYC count restarts.
- Async reset in READY: reset_n_i pulled low between edges → all outputs 0 before the next edge, state_o=0.
- Boundary: settle parameters = 1 → ref_en_o rises 1 edge after bias_en_o, and cal_start_o 1 edge after ref_en_o. done and timeout in the same cycle → READY.
